seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits; legal range 2..16.
REQ-002 Parameter CLK_DIV, default 40000, clk cycles per digit slot; legal range >= 1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  2  source select: 0=src0, 1=src1, 2=src2, 3=src3.
REQ-006 src0..src3  input  4*DIGITS each  hex data; nibble i drives digit i, nibble 0 is the rightmost digit.
REQ-007 dp  input  DIGITS  per-digit decimal point enable, 1=lit.
REQ-008 lzb  input  1  leading-zero blanking enable.
REQ-009 bright  input  4  brightness, 0 (dimmest, 1/16 duty) to 15 (full duty).
REQ-010 SEG  output  8  active-low segments; [6:0]=g..a, [7]=dp.
REQ-011 AN  output  DIGITS  active-low digit enables; at most one bit low at any time.
REQ-012 frame_tick  output  1  one-cycle pulse when a new frame snapshot is loaded.

Function
REQ-013 Divider cnt counts 0..CLK_DIV-1 and wraps; slot tick = (cnt == CLK_DIV-1); CLK_DIV=1 gives a tick every cycle.
REQ-014 On tick, pos increments; pos == DIGITS-1 on tick wraps to 0 (no 3-bit overflow dependence; non-power-of-2 DIGITS legal).
REQ-015 On tick with pos == DIGITS-1: shadow <= selected src per current mode, dp_sh <= dp, lzb_sh <= lzb, frame_tick = 1 next cycle.
REQ-016 Source, dp and lzb changes mid-frame are not visible until the next frame (no tearing).
REQ-017 Free-running 4-bit pwm counter increments every clk, wraps 15->0.
REQ-018 Digit pos is lit iff pwm <= bright and it is not blanked; when unlit, AN is all ones and SEG is all ones.
REQ-019 Blanking: digit i (i >= 1) is blanked when lzb_sh = 1 and shadow nibbles i..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-020 SEG[6:0] = hex pattern of shadow nibble pos (0-F, standard active-low glyphs incl. a,b,c,d,e,f); SEG[7] = ~dp_sh[pos].
REQ-021 AN, SEG are registered: they reflect pos, shadow and pwm with exactly one clk latency.
REQ-022 mode is sampled only at the frame boundary (REQ-015); a mode change mid-frame has no effect until then.
REQ-023 Simultaneous frame wrap and source change: the value present on the wrapping tick cycle is captured.

Reset
REQ-024 rst asserted: cnt=0, pos=0, pwm=0, shadow=0, dp_sh=0, lzb_sh=0, AN all ones, SEG all ones, frame_tick=0, immediately (async).
REQ-025 After rst release, the first output update is one clk later, showing digit 0 = "0" until the first frame wrap.
REQ-026 rst mid-frame abandons the frame; scan restarts at digit 0 with no frame_tick.

Structure
REQ-027 Shared package holds the 16 active-low glyph constants, the mode encodings and the SEG/AN all-off constant.
REQ-028 One combinational sub-module seg7_decode (4-bit nibble -> 7-bit active-low glyph) shall be used; all counters and registers stay in seg_scan_display.

Verification (bench uses DIGITS=8, CLK_DIV=4 unless noted)
REQ-029 mode=0, src0=32'h1234ABCD, bright=15, lzb=0 -> after first frame_tick, slots 0..7 show D,C,B,A,4,3,2,1 with AN=FE,FD,...,7F; slot 3 SEG=8'h88.
REQ-030 src1=32'h0000_00F0, mode=1, lzb=1 -> digits 0,1 show 0,F; digits 2..7 have AN all ones for their whole slot.
REQ-031 Change src0 from 32'h11111111 to 32'h22222222 while pos=3 -> remaining slots of that frame still show 1; next frame shows 2 from digit 0.
REQ-032 bright=3 -> within each slot, AN low exactly 4 of every 16 clks (pwm 0..3); bright=0 -> 1 of 16.
REQ-033 DIGITS=5, CLK_DIV=1 -> pos sequence 0,1,2,3,4,0; frame_tick every 5 clks; dp=5'b00100 lights SEG[7]=0 only on digit 2.
REQ-034 Assert rst for 1 clk at pos=5 -> AN=all ones and SEG=all ones asynchronously; after release scan restarts at digit 0, no frame_tick until 8 slots later.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Holds the active-low hex glyphs, the source-select encodings and the all-off drive levels.
package seg_scan_display_pkg;

    typedef enum logic [1:0] {
        MODE_SRC0 = 2'd0,
        MODE_SRC1 = 2'd1,
        MODE_SRC2 = 2'd2,
        MODE_SRC3 = 2'd3
    } mode_e;

    localparam logic [7:0]  SEG_OFF = 8'hFF;
    localparam logic [15:0] AN_OFF  = 16'hFFFF;

    // Active-low glyphs, bit order g..a, indexed by nibble value 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Nibble to active-low 7-segment glyph (g..a); purely combinational.
module seg7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph_c
);

    assign o_glyph_c = GLYPHS[i_nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display scanner with frame-snapshot sources,
// leading-zero blanking and 16-step PWM brightness.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned CLK_DIV = 40000
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_mode,
    input  logic [4*DIGITS-1:0]   i_src0,
    input  logic [4*DIGITS-1:0]   i_src1,
    input  logic [4*DIGITS-1:0]   i_src2,
    input  logic [4*DIGITS-1:0]   i_src3,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_lzb,
    input  logic [3:0]            i_bright,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frame_tick
);

    localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned POS_W  = $clog2(DIGITS);
    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIGITS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [POS_W-1:0]  r_pos;
    logic [3:0]        r_pwm;
    logic [DATA_W-1:0] r_shadow;
    logic [DIGITS-1:0] r_dp_sh;
    logic              r_lzb_sh;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              r_frame_tick;

    logic              w_tick;
    logic              w_wrap;
    logic [DATA_W-1:0] w_src_sel;
    logic [3:0]        w_nibble;
    logic [6:0]        w_glyph;
    logic              w_dp_bit;
    logic              w_zero_run;
    logic              w_blank;
    logic              w_lit;
    logic [DIGITS-1:0] w_an_nxt;
    logic [7:0]        w_seg_nxt;

    assign w_tick = (r_cnt == CNT_MAX);
    assign w_wrap = w_tick && (r_pos == POS_MAX);

    always_comb begin
        w_src_sel = i_src0;
        case (mode_e'(i_mode))
            MODE_SRC1: w_src_sel = i_src1;
            MODE_SRC2: w_src_sel = i_src2;
            MODE_SRC3: w_src_sel = i_src3;
            default:   w_src_sel = i_src0;
        endcase
    end

    // Walk from the top digit down so the zero run covers nibbles i..DIGITS-1.
    always_comb begin
        w_nibble   = '0;
        w_dp_bit   = 1'b0;
        w_zero_run = 1'b1;
        w_blank    = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (r_shadow[4*i +: 4] == 4'd0);
            if (POS_W'(i) == r_pos) begin
                w_nibble = r_shadow[4*i +: 4];
                w_dp_bit = r_dp_sh[i];
                w_blank  = r_lzb_sh & w_zero_run & (i != 0);
            end
        end
    end

    seg7_decode u_decode (
        .i_nibble  (w_nibble),
        .o_glyph_c (w_glyph)
    );

    assign w_lit = (r_pwm <= i_bright) && !w_blank;

    always_comb begin
        w_an_nxt  = AN_OFF[DIGITS-1:0];
        w_seg_nxt = SEG_OFF;
        if (w_lit) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (POS_W'(i) == r_pos) begin
                    w_an_nxt[i] = 1'b0;
                end
            end
            w_seg_nxt = {~w_dp_bit, w_glyph};
        end
    end

    // Counters, frame snapshot and registered display drive.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_pos        <= '0;
            r_pwm        <= '0;
            r_shadow     <= '0;
            r_dp_sh      <= '0;
            r_lzb_sh     <= 1'b0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF[DIGITS-1:0];
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_pwm        <= r_pwm + 4'd1;
            r_frame_tick <= w_wrap;
            if (w_tick) begin
                r_pos <= w_wrap ? '0 : r_pos + POS_W'(1);
            end
            if (w_wrap) begin
                r_shadow <= w_src_sel;
                r_dp_sh  <= i_dp;
                r_lzb_sh <= i_lzb;
            end
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign o_seg        = r_seg;
    assign o_an         = r_an;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed tables, hand sequences for
// reset/tearing/duty/5-digit corner cases, and randomized traffic against a timeline model.
module tb_seg_scan_display;

    localparam int unsigned D = 8;
    localparam int unsigned C = 4;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] src;
        logic        lzb;
        int          slot;
        logic [7:0]  an;
        logic [7:0]  seg;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [1:0]  mode   = 2'd0;
    logic [31:0] src0   = '0;
    logic [31:0] src1   = '0;
    logic [31:0] src2   = '0;
    logic [31:0] src3   = '0;
    logic [7:0]  dp     = '0;
    logic        lzb    = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        ft;

    logic        rst5    = 1'b1;
    logic [19:0] s5_src0 = '0;
    logic [19:0] s5_src1 = 20'hFFFFF;
    logic [19:0] s5_src2 = 20'h12345;
    logic [19:0] s5_src3 = 20'hABCDE;
    logic [4:0]  s5_dp   = 5'b00100;
    logic [7:0]  seg5;
    logic [4:0]  an5;
    logic        ft5;

    int n_vec = 0;
    int n_bad = 0;

    // Timeline model: m_k counts rising edges since reset release.
    int unsigned m_k   = 0;
    logic [31:0] m_sh  = '0;
    logic [7:0]  m_dp  = '0;
    logic        m_lzb = 1'b0;
    logic [7:0]  e_an  = 8'hFF;
    logic [7:0]  e_seg = 8'hFF;
    logic        e_ft  = 1'b0;

    // Active-high segment maps (bit0 = a); the display drives their complement.
    logic [7:0] lit_map [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    seg_scan_display #(.DIGITS(D), .CLK_DIV(C)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode       (mode),
        .i_src0       (src0),
        .i_src1       (src1),
        .i_src2       (src2),
        .i_src3       (src3),
        .i_dp         (dp),
        .i_lzb        (lzb),
        .i_bright     (bright),
        .o_seg        (seg),
        .o_an         (an),
        .o_frame_tick (ft)
    );

    seg_scan_display #(.DIGITS(5), .CLK_DIV(1)) dut5 (
        .i_clk        (clk),
        .i_rst        (rst5),
        .i_mode       (2'd0),
        .i_src0       (s5_src0),
        .i_src1       (s5_src1),
        .i_src2       (s5_src2),
        .i_src3       (s5_src3),
        .i_dp         (s5_dp),
        .i_lzb        (1'b0),
        .i_bright     (4'hF),
        .o_seg        (seg5),
        .o_an         (an5),
        .o_frame_tick (ft5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        logic [7:0] hi;
        hi = lit_map[n];
        return ~hi[6:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int unsigned p;
        int unsigned pw;
        logic [3:0]  nib;
        logic        blank;
        logic        lit;
        if (rst) begin
            m_k   = 0;
            m_sh  = '0;
            m_dp  = '0;
            m_lzb = 1'b0;
            e_an  = 8'hFF;
            e_seg = 8'hFF;
            e_ft  = 1'b0;
        end else begin
            p     = (m_k / C) % D;
            pw    = m_k % 16;
            nib   = m_sh[4*p +: 4];
            blank = m_lzb && (p >= 1) && ((m_sh >> (4*p)) == 32'd0);
            lit   = (pw <= 32'(bright)) && !blank;
            e_an  = lit ? ~(8'd1 << p) : 8'hFF;
            e_seg = lit ? {~m_dp[p], ref_glyph(nib)} : 8'hFF;
            m_k++;
            e_ft  = ((m_k % (C*D)) == 0);
            if (e_ft) begin
                case (mode)
                    2'd0: m_sh = src0;
                    2'd1: m_sh = src1;
                    2'd2: m_sh = src2;
                    default: m_sh = src3;
                endcase
                m_dp  = dp;
                m_lzb = lzb;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Continuous comparison of the 8-digit instance against the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("model_rst_an", 32'(an), 32'hFF);
            check("model_rst_seg", 32'(seg), 32'hFF);
            check("model_rst_ft", 32'(ft), 32'd0);
        end else begin
            check("model_an", 32'(an), 32'(e_an));
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_ft", 32'(ft), 32'(e_ft));
        end
    end

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ft !== 1'b1 && n < 100);
        check("frame_tick_seen", 32'(ft), 32'd1);
    endtask

    vec_t tbl [16];

    initial begin
        int cnt;
        logic [4:0] an5_exp;

        tbl[0]  = '{2'd0, 32'h1234ABCD, 1'b0, 0, 8'hFE, 8'hA1};
        tbl[1]  = '{2'd0, 32'h1234ABCD, 1'b0, 1, 8'hFD, 8'hC6};
        tbl[2]  = '{2'd0, 32'h1234ABCD, 1'b0, 2, 8'hFB, 8'h83};
        tbl[3]  = '{2'd0, 32'h1234ABCD, 1'b0, 3, 8'hF7, 8'h88};
        tbl[4]  = '{2'd0, 32'h1234ABCD, 1'b0, 4, 8'hEF, 8'h99};
        tbl[5]  = '{2'd0, 32'h1234ABCD, 1'b0, 5, 8'hDF, 8'hB0};
        tbl[6]  = '{2'd0, 32'h1234ABCD, 1'b0, 6, 8'hBF, 8'hA4};
        tbl[7]  = '{2'd0, 32'h1234ABCD, 1'b0, 7, 8'h7F, 8'hF9};
        tbl[8]  = '{2'd1, 32'h000000F0, 1'b1, 0, 8'hFE, 8'hC0};
        tbl[9]  = '{2'd1, 32'h000000F0, 1'b1, 1, 8'hFD, 8'h8E};
        tbl[10] = '{2'd1, 32'h000000F0, 1'b1, 2, 8'hFF, 8'hFF};
        tbl[11] = '{2'd1, 32'h000000F0, 1'b1, 3, 8'hFF, 8'hFF};
        tbl[12] = '{2'd1, 32'h000000F0, 1'b1, 4, 8'hFF, 8'hFF};
        tbl[13] = '{2'd1, 32'h000000F0, 1'b1, 5, 8'hFF, 8'hFF};
        tbl[14] = '{2'd1, 32'h000000F0, 1'b1, 6, 8'hFF, 8'hFF};
        tbl[15] = '{2'd1, 32'h000000F0, 1'b1, 7, 8'hFF, 8'hFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_ft", 32'(ft), 32'd0);
        check("reset_an5", 32'(an5), 32'h1F);
        #2;
        rst  = 1'b0;
        rst5 = 1'b0;

        // First update after release, plus 5-digit / CLK_DIV=1 scan
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_an", 32'(an), 32'hFE);
                check("first_seg", 32'(seg), 32'hC0);
            end
            an5_exp = ~(5'd1 << ((k - 1) % 5));
            check($sformatf("d5_an_k%0d", k), 32'(an5), 32'(an5_exp));
            check($sformatf("d5_seg_k%0d", k), 32'(seg5), (k == 8) ? 32'h40 : 32'hC0);
            check($sformatf("d5_ft_k%0d", k), 32'(ft5), (k % 5 == 0) ? 32'd1 : 32'd0);
        end

        // Table: per-slot AN/SEG after a frame snapshot
        for (int r = 0; r < 16; r++) begin
            mode   = tbl[r].mode;
            src0   = ~tbl[r].src;
            src1   = ~tbl[r].src;
            src2   = ~tbl[r].src;
            src3   = ~tbl[r].src;
            case (tbl[r].mode)
                2'd0: src0 = tbl[r].src;
                2'd1: src1 = tbl[r].src;
                2'd2: src2 = tbl[r].src;
                default: src3 = tbl[r].src;
            endcase
            lzb    = tbl[r].lzb;
            dp     = '0;
            bright = 4'hF;
            wait_frame();
            repeat (1 + C * tbl[r].slot) @(negedge clk);
            for (int c = 0; c < int'(C); c++) begin
                check($sformatf("tbl%0d_an_c%0d", r, c), 32'(an), 32'(tbl[r].an));
                check($sformatf("tbl%0d_seg_c%0d", r, c), 32'(seg), 32'(tbl[r].seg));
                if (c < int'(C) - 1) @(negedge clk);
            end
        end

        // Mid-frame source change must not tear
        mode = 2'd0;
        lzb  = 1'b0;
        src0 = 32'h11111111;
        wait_frame();
        repeat (1 + C * 3) @(negedge clk);
        src0 = 32'h22222222;
        for (int s = 3; s < int'(D); s++) begin
            check($sformatf("tear_slot%0d", s), 32'(seg), 32'hF9);
            repeat (C) @(negedge clk);
        end
        check("tear_next_frame_d0", 32'(seg), 32'hA4);

        // PWM duty over a 64-clock window
        bright = 4'd3;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an !== 8'hFF) cnt++;
        end
        check("duty_bright3", 32'(cnt), 32'd16);
        bright = 4'd0;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an !== 8'hFF) cnt++;
        end
        check("duty_bright0", 32'(cnt), 32'd4);

        // Async reset mid-frame at digit 5
        bright = 4'hF;
        wait_frame();
        repeat (1 + C * 5) @(negedge clk);
        check("pre_rst_an", 32'(an), 32'hDF);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hFF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        check("async_rst_ft", 32'(ft), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("restart_an", 32'(an), 32'hFE);
        end while (ft !== 1'b1 && cnt < 100);
        check("restart_ft_gap", 32'(cnt), 32'(C * D));

        // Randomized traffic checked by the continuous model comparison
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 9) == 0)  mode   = 2'($urandom);
            if ($urandom_range(0, 15) == 0) src0   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) src1   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) src2   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) src3   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) dp     = 8'($urandom);
            if ($urandom_range(0, 15) == 0) lzb    = 1'($urandom);
            if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
